sprite_frame_scheduler: RTL and testbench

//  Sequences all updates to on-screen object state (sprite x/y, visibility, health) driven by the MCU.

---
 rtl/sprite_frame_scheduler_pkg.sv | 29 ++
 rtl/sprite_frame_scheduler_cmd_parser.sv | 84 ++++++++
 rtl/sprite_frame_scheduler.sv | 104 ++++++++++
 tb/tb_sprite_frame_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_frame_scheduler_pkg.sv
// Shared types for the sprite frame scheduler: opcodes, parser states, per-object state.
package sprite_pkg;

  typedef enum logic [3:0] {
    OP_SET_X   = 4'd1,
    OP_SET_Y   = 4'd2,
    OP_SET_VIS = 4'd3,
    OP_SET_HP  = 4'd4
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2,
    EXEC = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic [7:0] hp;
  } obj_state_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

endpackage

// File: rtl/sprite_frame_scheduler_cmd_parser.sv
// Assembles 3-byte commands, validates op/id at EXEC and emits a one-cycle write or error pulse.
module cmd_parser
  import sprite_pkg::*;
#(
  parameter int NOBJ    = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_id,
  output logic [3:0]  o_wr_op,
  output logic [15:0] o_wr_arg,
  output logic        o_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  parse_state_e r_state;
  logic [CW-1:0] r_idle;
  logic [7:0]    r_b0;
  logic [15:0]   r_arg;
  logic          r_wr_en;
  logic          r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idle  <= '0;
      r_b0    <= '0;
      r_arg   <= '0;
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_idle <= '0;
          if (i_rx_valid) begin
            r_b0    <= i_rx_byte;
            r_state <= GOT0;
          end
        end
        GOT0, GOT1: begin
          if (i_rx_valid) begin
            r_idle <= '0;
            if (r_state == GOT0) begin
              r_arg[15:8] <= i_rx_byte;
              r_state     <= GOT1;
            end else begin
              r_arg[7:0] <= i_rx_byte;
              r_state    <= EXEC;
            end
          end else if (r_idle == CW'(TIMEOUT - 1)) begin
            // Stalled mid-command: drop the partial bytes and count it as an error.
            r_idle  <= '0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        EXEC: begin
          r_state <= IDLE;
          if (is_valid_op(r_b0[7:4]) && ({1'b0, r_b0[3:0]} < 5'(NOBJ)))
            r_wr_en <= 1'b1;
          else
            r_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_en  = r_wr_en;
  assign o_err    = r_err;
  assign o_wr_id  = r_b0[3:0];
  assign o_wr_op  = r_b0[7:4];
  assign o_wr_arg = r_arg;

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Shadow/active object register file; shadow commits to active atomically on each vsync falling edge.
module sprite_frame_scheduler
  import sprite_pkg::*;
#(
  parameter int NOBJ    = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic               vgaclk,
  input  logic               reset,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               vsync,
  output logic [NOBJ*10-1:0] obj_x,
  output logic [NOBJ*10-1:0] obj_y,
  output logic [NOBJ-1:0]    obj_vis,
  output logic [NOBJ*8-1:0]  obj_hp,
  output logic [7:0]         frame_cnt,
  output logic [7:0]         err_cnt,
  output logic               dirty
);

  logic        w_wr_en;
  logic        w_err;
  logic [3:0]  w_wr_id;
  logic [3:0]  w_wr_op;
  logic [15:0] w_wr_arg;
  logic        w_fall;

  obj_state_t r_shadow [NOBJ];
  obj_state_t r_active [NOBJ];
  logic       r_vsync_q;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_err_cnt;
  logic       r_dirty;

  cmd_parser #(
    .NOBJ    (NOBJ),
    .TIMEOUT (TIMEOUT)
  ) u_cmd_parser (
    .i_clk      (vgaclk),
    .i_reset    (reset),
    .i_rx_byte  (rx_byte),
    .i_rx_valid (rx_valid),
    .o_wr_en    (w_wr_en),
    .o_wr_id    (w_wr_id),
    .o_wr_op    (w_wr_op),
    .o_wr_arg   (w_wr_arg),
    .o_err      (w_err)
  );

  assign w_fall = r_vsync_q & ~vsync;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      for (int i = 0; i < NOBJ; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_vsync_q   <= 1'b1;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_dirty     <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_fall)
        r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_err && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
      // Active takes the pre-write shadow when a write lands on the fall cycle.
      if (w_fall && r_dirty) begin
        for (int i = 0; i < NOBJ; i++)
          r_active[i] <= r_shadow[i];
      end
      for (int i = 0; i < NOBJ; i++) begin
        if (w_wr_en && (w_wr_id == 4'(i))) begin
          case (opcode_e'(w_wr_op))
            OP_SET_X:   r_shadow[i].x   <= w_wr_arg[9:0];
            OP_SET_Y:   r_shadow[i].y   <= w_wr_arg[9:0];
            OP_SET_VIS: r_shadow[i].vis <= w_wr_arg[0];
            OP_SET_HP:  r_shadow[i].hp  <= w_wr_arg[7:0];
            default:    ;
          endcase
        end
      end
      if (w_wr_en)
        r_dirty <= 1'b1;
      else if (w_fall)
        r_dirty <= 1'b0;
    end
  end

  genvar g;
  for (g = 0; g < NOBJ; g++) begin : g_pack
    assign obj_x[10*g +: 10] = r_active[g].x;
    assign obj_y[10*g +: 10] = r_active[g].y;
    assign obj_vis[g]        = r_active[g].vis;
    assign obj_hp[8*g +: 8]  = r_active[g].hp;
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign dirty     = r_dirty;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: command parsing, errors, timeout and frame-atomic commit.
module tb_sprite_frame_scheduler;

  localparam int NOBJ    = 4;
  localparam int TIMEOUT = 32;

  logic               vgaclk = 1'b0;
  logic               reset  = 1'b1;
  logic [7:0]         rx_byte = 8'h00;
  logic               rx_valid = 1'b0;
  logic               vsync = 1'b1;
  logic [NOBJ*10-1:0] obj_x;
  logic [NOBJ*10-1:0] obj_y;
  logic [NOBJ-1:0]    obj_vis;
  logic [NOBJ*8-1:0]  obj_hp;
  logic [7:0]         frame_cnt;
  logic [7:0]         err_cnt;
  logic               dirty;

  int checks   = 0;
  int failures = 0;

  sprite_frame_scheduler #(.NOBJ(NOBJ), .TIMEOUT(TIMEOUT)) dut (
    .vgaclk    (vgaclk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .vsync     (vsync),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .obj_vis   (obj_vis),
    .obj_hp    (obj_hp),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .dirty     (dirty)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic do_reset();
    @(negedge vgaclk);
    reset = 1'b1; rx_valid = 1'b0; vsync = 1'b1;
    repeat (2) @(negedge vgaclk);
    reset = 1'b0;
    @(negedge vgaclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge vgaclk);
    rx_valid = 1'b0;
    repeat (8) @(negedge vgaclk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    repeat (2) @(negedge vgaclk);
    vsync = 1'b1;
    repeat (2) @(negedge vgaclk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({obj_x, obj_y, obj_vis, obj_hp} !== '0) begin
      failures++; $display("FAIL reset_objs got=%h exp=0", {obj_x, obj_y, obj_vis, obj_hp});
    end
    checks++;
    if ({frame_cnt, err_cnt, dirty} !== 17'd0) begin
      failures++; $display("FAIL reset_ctrl got frame=%0d err=%0d dirty=%b exp 0/0/0", frame_cnt, err_cnt, dirty);
    end
  endtask

  task automatic test_set_x();
    do_reset();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h64);
    checks++;
    if (obj_x[9:0] !== 10'd0) begin
      failures++; $display("FAIL setx_before_fall got=%0d exp=0", obj_x[9:0]);
    end
    checks++;
    if (dirty !== 1'b1) begin
      failures++; $display("FAIL setx_dirty_pending got=%b exp=1", dirty);
    end
    vsync_pulse();
    checks++;
    if (obj_x[9:0] !== 10'd100) begin
      failures++; $display("FAIL setx_after_fall got=%0d exp=100", obj_x[9:0]);
    end
    checks++;
    if (dirty !== 1'b0 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL setx_commit got dirty=%b frame=%0d exp 0/1", dirty, frame_cnt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (err_cnt !== 8'd2 || dirty !== 1'b0) begin
      failures++; $display("FAIL err_count got err=%0d dirty=%b exp 2/0", err_cnt, dirty);
    end
    vsync_pulse();
    checks++;
    if ({obj_x, obj_y, obj_vis, obj_hp} !== '0 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL err_no_change got objs=%h frame=%0d exp 0/1", {obj_x, obj_y, obj_vis, obj_hp}, frame_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h21);
    rx_byte = 8'h01; rx_valid = 1'b1;
    @(negedge vgaclk);
    rx_valid = 1'b0;
    repeat (TIMEOUT - 6) @(negedge vgaclk);
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++; $display("FAIL timeout_early got=%0d exp=0", err_cnt);
    end
    repeat (10) @(negedge vgaclk);
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++; $display("FAIL timeout_err got=%0d exp=1", err_cnt);
    end
    send_byte(8'h41); send_byte(8'h00); send_byte(8'h32);
    vsync_pulse();
    checks++;
    if (obj_hp[15:8] !== 8'd50 || obj_y[19:10] !== 10'd0) begin
      failures++; $display("FAIL timeout_recover got hp1=%0d y1=%0d exp 50/0", obj_hp[15:8], obj_y[19:10]);
    end
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++; $display("FAIL timeout_err_final got=%0d exp=1", err_cnt);
    end
  endtask

  task automatic test_fall_collision();
    do_reset();
    send_byte(8'h13); send_byte(8'h01);
    rx_byte = 8'h55; rx_valid = 1'b1;
    @(negedge vgaclk);
    rx_valid = 1'b0;
    @(negedge vgaclk);
    vsync = 1'b0;
    repeat (2) @(negedge vgaclk);
    checks++;
    if (obj_x[39:30] !== 10'd0 || dirty !== 1'b1 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL collide_frame got x3=%0d dirty=%b frame=%0d exp 0/1/1", obj_x[39:30], dirty, frame_cnt);
    end
    vsync = 1'b1;
    repeat (2) @(negedge vgaclk);
    vsync_pulse();
    checks++;
    if (obj_x[39:30] !== 10'd341 || dirty !== 1'b0 || frame_cnt !== 8'd2) begin
      failures++; $display("FAIL collide_next got x3=%0d dirty=%b frame=%0d exp 341/0/2", obj_x[39:30], dirty, frame_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h77);
    for (int i = 0; i < 255; i++) vsync_pulse();
    checks++;
    if (frame_cnt !== 8'd255 || obj_hp[7:0] !== 8'h77) begin
      failures++; $display("FAIL wrap_255 got frame=%0d hp0=%h exp 255/77", frame_cnt, obj_hp[7:0]);
    end
    vsync_pulse();
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++; $display("FAIL wrap_0 got=%0d exp=0", frame_cnt);
    end
    send_byte(8'h10); send_byte(8'h01);
    reset = 1'b1;
    @(negedge vgaclk);
    reset = 1'b0;
    @(negedge vgaclk);
    checks++;
    if ({obj_x, obj_y, obj_vis, obj_hp, frame_cnt, err_cnt, dirty} !== '0) begin
      failures++; $display("FAIL midcmd_reset got=%h exp=0", {obj_x, obj_y, obj_vis, obj_hp, frame_cnt, err_cnt, dirty});
    end
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h2A);
    vsync_pulse();
    checks++;
    if (obj_x[29:20] !== 10'd42 || err_cnt !== 8'd0 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL after_reset_cmd got x2=%0d err=%0d frame=%0d exp 42/0/1", obj_x[29:20], err_cnt, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h12); send_byte(8'h01); send_byte(8'h23);
    send_byte(8'h22); send_byte(8'h02); send_byte(8'h0A);
    send_byte(8'h32); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'hC8);
    checks++;
    if (obj_x[29:20] !== 10'd0 || obj_y[29:20] !== 10'd0 || obj_vis[2] !== 1'b0 || obj_hp[23:16] !== 8'd0) begin
      failures++; $display("FAIL b2b_before got x=%0d y=%0d vis=%b hp=%0d exp all 0", obj_x[29:20], obj_y[29:20], obj_vis[2], obj_hp[23:16]);
    end
    vsync = 1'b0;
    @(negedge vgaclk);
    checks++;
    if (obj_x[29:20] !== 10'd291 || obj_y[29:20] !== 10'd522 || obj_vis[2] !== 1'b1 || obj_hp[23:16] !== 8'd200) begin
      failures++; $display("FAIL b2b_commit got x=%0d y=%0d vis=%b hp=%0d exp 291/522/1/200", obj_x[29:20], obj_y[29:20], obj_vis[2], obj_hp[23:16]);
    end
    checks++;
    if (obj_x[9:0] !== 10'd0 || obj_vis[1:0] !== 2'b00 || obj_vis[3] !== 1'b0) begin
      failures++; $display("FAIL b2b_others got x0=%0d vis=%b exp 0/0", obj_x[9:0], obj_vis);
    end
    vsync = 1'b1;
    repeat (2) @(negedge vgaclk);
  endtask

  initial begin
    test_reset();
    test_set_x();
    test_errors();
    test_timeout();
    test_fall_collision();
    test_wrap_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
